// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, CC codes,
// memory opcode encodings and the condition-code helper.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_F000;

  // Encodings mirror global_def.h
  localparam logic [7:0] OP_LDB = 8'b0100_0000;
  localparam logic [7:0] OP_LDW = 8'b0100_0001;
  localparam logic [7:0] OP_STB = 8'b0100_0010;
  localparam logic [7:0] OP_STW = 8'b0100_0011;

  function automatic logic [2:0] cc_of(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    if (s < 0)
      return CC_N;
    else if (s == 0)
      return CC_Z;
    else
      return CC_P;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port of the memory stage; master = pipeline side,
// slave = memory side.
interface mem_stage_if;
  logic        O_DMemReq;
  logic        O_DMemWE;
  logic [29:0] O_DMemAddr;
  logic [31:0] O_DMemWData;
  logic        I_DMemAck;
  logic [31:0] I_DMemRData;

  modport master (
    output O_DMemReq, O_DMemWE, O_DMemAddr, O_DMemWData,
    input  I_DMemAck, I_DMemRData
  );

  modport slave (
    input  O_DMemReq, O_DMemWE, O_DMemAddr, O_DMemWData,
    output I_DMemAck, I_DMemRData
  );
endinterface

// File: rtl/mem_stage_fsm.sv
// dmem_req_fsm: IDLE/REQ handshake controller with an ack timeout counter.
// Updates on the falling clock edge like the rest of the pipeline.
module dmem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic done_ack,
  output logic done_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An ack arriving on the timeout edge takes priority over the abort
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          done_timeout = 1'b1;
          state_d      = IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign req   = (state_q == REQ);
  assign stall = (state_q == REQ);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: LDW/STW via req/ack data memory, single-cycle pass
// for everything else. Optional LED MMIO register: MEM_STAGE_MMIO_LEDR_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
`ifdef MEM_STAGE_MMIO_LEDR_EN
  , parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
`endif
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic        I_LOCK,
  input  logic        I_EX_Valid,
  input  logic [31:0] I_PC,
  input  logic [31:0] I_IR,
  input  logic [7:0]  I_Opcode,
  input  logic [3:0]  I_DestRegIdx,
  input  logic [5:0]  I_DestVRegIdx,
  input  logic [31:0] I_DestValue,
  input  logic [63:0] I_VecDestValue,
  input  logic [2:0]  I_CCValue,
  input  logic        I_RegWEn,
  input  logic        I_VRegWEn,
  input  logic        I_CCWEn,
  input  logic [31:0] I_MARValue,
  input  logic [31:0] I_MDRValue,
  mem_stage_if.master dmem,
  output logic        O_MEMStallSignal,
  output logic        O_LOCK,
  output logic        O_MEM_Valid,
  output logic [31:0] O_PC,
  output logic [31:0] O_IR,
  output logic [7:0]  O_Opcode,
  output logic [3:0]  O_DestRegIdx,
  output logic [5:0]  O_DestVRegIdx,
  output logic [31:0] O_DestValue,
  output logic [63:0] O_VecDestValue,
  output logic [2:0]  O_CCValue,
  output logic        O_RegWEn,
  output logic        O_VRegWEn,
  output logic        O_CCWEn,
  output logic        O_MemFault
`ifdef MEM_STAGE_MMIO_LEDR_EN
  , output logic [9:0] O_LEDR
`endif
);

  logic fsm_req, fsm_stall, done_ack, done_timeout;
  logic accept, is_word, is_byte, aligned, mmio_hit, mem_go;

  assign is_word = I_EX_Valid && ((I_Opcode == OP_LDW) || (I_Opcode == OP_STW));
  assign is_byte = I_EX_Valid && ((I_Opcode == OP_LDB) || (I_Opcode == OP_STB));
  assign aligned = (I_MARValue[1:0] == 2'b00);
`ifdef MEM_STAGE_MMIO_LEDR_EN
  assign mmio_hit = is_word && aligned && (I_MARValue == MMIO_BASE);
`else
  assign mmio_hit = 1'b0;
`endif
  assign accept = !fsm_stall && I_LOCK;
  assign mem_go = accept && is_word && aligned && !mmio_hit;

  dmem_req_fsm #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_fsm (
    .clk          (I_CLOCK),
    .rst          (I_RESET),
    .start        (mem_go),
    .ack          (dmem.I_DMemAck),
    .req          (fsm_req),
    .stall        (fsm_stall),
    .done_ack     (done_ack),
    .done_timeout (done_timeout)
  );

  // ---- stage p0: instruction held while the access is outstanding ----
  logic        ld_p0, we_p0;
  logic [29:0] addr_p0;
  logic [31:0] wdata_p0, pc_p0, ir_p0, dval_p0;
  logic [7:0]  opc_p0;
  logic [3:0]  rd_p0;
  logic [5:0]  vrd_p0;
  logic [63:0] vdval_p0;
  logic [2:0]  cc_p0;

  always_ff @(negedge I_CLOCK) begin
    if (mem_go) begin
      ld_p0    <= (I_Opcode == OP_LDW);
      we_p0    <= (I_Opcode == OP_STW);
      addr_p0  <= I_MARValue[31:2];
      wdata_p0 <= I_MDRValue;
      pc_p0    <= I_PC;
      ir_p0    <= I_IR;
      opc_p0   <= I_Opcode;
      rd_p0    <= I_DestRegIdx;
      vrd_p0   <= I_DestVRegIdx;
      dval_p0  <= I_DestValue;
      vdval_p0 <= I_VecDestValue;
      cc_p0    <= I_CCValue;
    end
  end

  assign dmem.O_DMemReq   = fsm_req;
  assign dmem.O_DMemWE    = fsm_req & we_p0;
  assign dmem.O_DMemAddr  = fsm_req ? addr_p0 : '0;
  assign dmem.O_DMemWData = fsm_req ? wdata_p0 : '0;
  assign O_MEMStallSignal = fsm_stall;

  // ---- stage p1: output register toward Writeback ----
  logic        vld_p1, lock_p1, regwe_p1, vregwe_p1, ccwe_p1, fault_p1;
  logic [31:0] pc_p1, ir_p1, dval_p1;
  logic [7:0]  opc_p1;
  logic [3:0]  rd_p1;
  logic [5:0]  vrd_p1;
  logic [63:0] vdval_p1;
  logic [2:0]  cc_p1;
`ifdef MEM_STAGE_MMIO_LEDR_EN
  logic [9:0]  ledr_p1;
`endif

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      vld_p1    <= 1'b0;
      lock_p1   <= 1'b0;
      regwe_p1  <= 1'b0;
      vregwe_p1 <= 1'b0;
      ccwe_p1   <= 1'b0;
      fault_p1  <= 1'b0;
      pc_p1     <= '0;
      ir_p1     <= '0;
      dval_p1   <= '0;
      opc_p1    <= '0;
      rd_p1     <= '0;
      vrd_p1    <= '0;
      vdval_p1  <= '0;
      cc_p1     <= '0;
`ifdef MEM_STAGE_MMIO_LEDR_EN
      ledr_p1   <= '0;
`endif
    end else if (fsm_stall) begin
      if (done_ack || done_timeout) begin
        vld_p1    <= 1'b1;
        lock_p1   <= 1'b1;
        pc_p1     <= pc_p0;
        ir_p1     <= ir_p0;
        opc_p1    <= opc_p0;
        rd_p1     <= rd_p0;
        vrd_p1    <= vrd_p0;
        vdval_p1  <= vdval_p0;
        vregwe_p1 <= 1'b0;
        if (done_ack && ld_p0) begin
          dval_p1  <= dmem.I_DMemRData;
          regwe_p1 <= 1'b1;
          ccwe_p1  <= 1'b1;
          cc_p1    <= cc_of(dmem.I_DMemRData);
        end else begin
          dval_p1  <= dval_p0;
          regwe_p1 <= 1'b0;
          ccwe_p1  <= 1'b0;
          cc_p1    <= cc_p0;
        end
        if (done_timeout)
          fault_p1 <= 1'b1;
      end else begin
        vld_p1    <= 1'b0;
        regwe_p1  <= 1'b0;
        vregwe_p1 <= 1'b0;
        ccwe_p1   <= 1'b0;
      end
    end else if (!I_LOCK) begin
      lock_p1   <= 1'b0;
      vld_p1    <= 1'b0;
      regwe_p1  <= 1'b0;
      vregwe_p1 <= 1'b0;
      ccwe_p1   <= 1'b0;
    end else begin
      lock_p1   <= 1'b1;
      vld_p1    <= I_EX_Valid;
      pc_p1     <= I_PC;
      ir_p1     <= I_IR;
      opc_p1    <= I_Opcode;
      rd_p1     <= I_DestRegIdx;
      vrd_p1    <= I_DestVRegIdx;
      dval_p1   <= I_DestValue;
      vdval_p1  <= I_VecDestValue;
      cc_p1     <= I_CCValue;
      regwe_p1  <= I_RegWEn;
      vregwe_p1 <= I_VRegWEn;
      ccwe_p1   <= I_CCWEn;
      if (mem_go) begin
        vld_p1    <= 1'b0;
        regwe_p1  <= 1'b0;
        vregwe_p1 <= 1'b0;
        ccwe_p1   <= 1'b0;
      end else if (is_word && !aligned) begin
        regwe_p1  <= 1'b0;
        vregwe_p1 <= 1'b0;
        ccwe_p1   <= 1'b0;
        fault_p1  <= 1'b1;
      end else if (is_byte) begin
        regwe_p1  <= 1'b0;
        vregwe_p1 <= 1'b0;
        ccwe_p1   <= 1'b0;
      end
`ifdef MEM_STAGE_MMIO_LEDR_EN
      else if (mmio_hit) begin
        vregwe_p1 <= 1'b0;
        if (I_Opcode == OP_LDW) begin
          dval_p1  <= {22'b0, ledr_p1};
          regwe_p1 <= 1'b1;
          ccwe_p1  <= 1'b1;
          cc_p1    <= cc_of({22'b0, ledr_p1});
        end else begin
          ledr_p1  <= I_MDRValue[9:0];
          regwe_p1 <= 1'b0;
          ccwe_p1  <= 1'b0;
        end
      end
`endif
    end
  end

  assign O_LOCK         = lock_p1;
  assign O_MEM_Valid    = vld_p1;
  assign O_PC           = pc_p1;
  assign O_IR           = ir_p1;
  assign O_Opcode       = opc_p1;
  assign O_DestRegIdx   = rd_p1;
  assign O_DestVRegIdx  = vrd_p1;
  assign O_DestValue    = dval_p1;
  assign O_VecDestValue = vdval_p1;
  assign O_CCValue      = cc_p1;
  assign O_RegWEn       = regwe_p1;
  assign O_VRegWEn      = vregwe_p1;
  assign O_CCWEn        = ccwe_p1;
  assign O_MemFault     = fault_p1;
`ifdef MEM_STAGE_MMIO_LEDR_EN
  assign O_LEDR         = ledr_p1;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps plus randomized traffic
// against a word-addressed memory model and rule-based expected outputs.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;
  localparam logic [7:0] OP_ADD = 8'h00;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET, I_LOCK, I_EX_Valid;
  logic [31:0] I_PC, I_IR, I_DestValue, I_MARValue, I_MDRValue;
  logic [7:0]  I_Opcode;
  logic [3:0]  I_DestRegIdx;
  logic [5:0]  I_DestVRegIdx;
  logic [63:0] I_VecDestValue;
  logic [2:0]  I_CCValue;
  logic        I_RegWEn, I_VRegWEn, I_CCWEn;
  logic        O_MEMStallSignal, O_LOCK, O_MEM_Valid;
  logic [31:0] O_PC, O_IR, O_DestValue;
  logic [7:0]  O_Opcode;
  logic [3:0]  O_DestRegIdx;
  logic [5:0]  O_DestVRegIdx;
  logic [63:0] O_VecDestValue;
  logic [2:0]  O_CCValue;
  logic        O_RegWEn, O_VRegWEn, O_CCWEn, O_MemFault;
`ifdef MEM_STAGE_MMIO_LEDR_EN
  logic [9:0]  O_LEDR;
`endif

  mem_stage_if dmem ();

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_EX_Valid(I_EX_Valid),
    .I_PC(I_PC), .I_IR(I_IR), .I_Opcode(I_Opcode), .I_DestRegIdx(I_DestRegIdx),
    .I_DestVRegIdx(I_DestVRegIdx), .I_DestValue(I_DestValue),
    .I_VecDestValue(I_VecDestValue), .I_CCValue(I_CCValue), .I_RegWEn(I_RegWEn),
    .I_VRegWEn(I_VRegWEn), .I_CCWEn(I_CCWEn), .I_MARValue(I_MARValue),
    .I_MDRValue(I_MDRValue), .dmem(dmem), .O_MEMStallSignal(O_MEMStallSignal),
    .O_LOCK(O_LOCK), .O_MEM_Valid(O_MEM_Valid), .O_PC(O_PC), .O_IR(O_IR),
    .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx), .O_DestVRegIdx(O_DestVRegIdx),
    .O_DestValue(O_DestValue), .O_VecDestValue(O_VecDestValue),
    .O_CCValue(O_CCValue), .O_RegWEn(O_RegWEn), .O_VRegWEn(O_VRegWEn),
    .O_CCWEn(O_CCWEn), .O_MemFault(O_MemFault)
`ifdef MEM_STAGE_MMIO_LEDR_EN
    , .O_LEDR(O_LEDR)
`endif
  );

  always #5 I_CLOCK = ~I_CLOCK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit exp_fault = 1'b0;
  logic [31:0] mem [logic [29:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge I_CLOCK);
    #1;
  endtask

  function automatic logic [2:0] cc_ref(input logic [31:0] v);
    int signed s;
    s = v;
    if (s > 0) return 3'b001;
    if (s < 0) return 3'b100;
    return 3'b010;
  endfunction

  task automatic mem_rd(input logic [29:0] a, output logic [31:0] d);
    if (!mem.exists(a)) mem[a] = $urandom;
    d = mem[a];
  endtask

  task automatic drive(input logic [7:0] op, input logic valid, input logic [31:0] pc,
                       input logic [31:0] mar, input logic [31:0] mdr,
                       input logic [31:0] dval, input logic [2:0] cc);
    I_LOCK = 1'b1; I_EX_Valid = valid; I_Opcode = op; I_PC = pc; I_IR = $urandom;
    I_DestRegIdx = 4'($urandom); I_DestVRegIdx = 6'($urandom);
    I_DestValue = dval; I_VecDestValue = {$urandom, $urandom}; I_CCValue = cc;
    I_RegWEn = 1'b1; I_VRegWEn = 1'b0; I_CCWEn = 1'b1;
    I_MARValue = mar; I_MDRValue = mdr;
    dmem.I_DMemAck = 1'b0;
  endtask

  // lat = REQ edges without ack before the ack edge; lat >= TO never acks
  task automatic exec(input string tag, input logic [7:0] op, input logic valid,
                      input logic [31:0] mar, input logic [31:0] mdr,
                      input logic [31:0] dval, input int lat);
    logic [31:0] pc, rd, exp_d;
    logic [2:0]  cc, exp_cc;
    bit ld, st, misal, access, bop, acked, exp_we;
    pc = $urandom;
    cc = 3'(1 << $urandom_range(0, 2));
    ld = valid && (op == OP_LDW);
    st = valid && (op == OP_STW);
    misal = (ld || st) && (mar[1:0] != 2'b00);
    access = (ld || st) && !misal;
    bop = valid && ((op == OP_LDB) || (op == OP_STB));
    acked = 1'b0;
    rd = '0;
    drive(op, valid, pc, mar, mdr, dval, cc);
    tick();
    if (access) begin
      chk({tag, ".stall"}, 64'(O_MEMStallSignal), 64'(1));
      chk({tag, ".req"}, 64'(dmem.O_DMemReq), 64'(1));
      chk({tag, ".addr"}, 64'(dmem.O_DMemAddr), 64'(mar >> 2));
      chk({tag, ".we"}, 64'(dmem.O_DMemWE), 64'(st));
      chk({tag, ".vld0"}, 64'(O_MEM_Valid), 64'(0));
      if (st) chk({tag, ".wdata"}, 64'(dmem.O_DMemWData), 64'(mdr));
      for (int e = 1; e <= TO; e++) begin
        I_LOCK = 1'($urandom_range(0, 1));
        if (e == lat + 1) begin
          if (ld) mem_rd(mar[31:2], rd); else rd = $urandom;
          dmem.I_DMemAck = 1'b1;
          dmem.I_DMemRData = rd;
        end
        tick();
        dmem.I_DMemAck = 1'b0;
        if (e == lat + 1) begin
          acked = 1'b1;
          break;
        end
        if (e < TO) begin
          chk({tag, ".hold_stall"}, 64'(O_MEMStallSignal), 64'(1));
          chk({tag, ".hold_addr"}, 64'(dmem.O_DMemAddr), 64'(mar >> 2));
        end
      end
      if (acked && st) mem[mar[31:2]] = mdr;
      if (!acked) exp_fault = 1'b1;
      exp_we = acked && ld;
      exp_cc = exp_we ? cc_ref(rd) : cc;
      chk({tag, ".vld"}, 64'(O_MEM_Valid), 64'(1));
      chk({tag, ".regwe"}, 64'(O_RegWEn), 64'(exp_we));
      chk({tag, ".ccwe"}, 64'(O_CCWEn), 64'(exp_we));
      chk({tag, ".vregwe"}, 64'(O_VRegWEn), 64'(0));
      chk({tag, ".cc"}, 64'(O_CCValue), 64'(exp_cc));
      chk({tag, ".pc"}, 64'(O_PC), 64'(pc));
      chk({tag, ".req_end"}, 64'(dmem.O_DMemReq), 64'(0));
      chk({tag, ".stall_end"}, 64'(O_MEMStallSignal), 64'(0));
      chk({tag, ".fault"}, 64'(O_MemFault), 64'(exp_fault));
      if (exp_we) chk({tag, ".data"}, 64'(O_DestValue), 64'(rd));
    end else begin
      if (misal) exp_fault = 1'b1;
      exp_we = !(misal || bop);
      exp_d = dval;
      chk({tag, ".vld"}, 64'(O_MEM_Valid), 64'(valid));
      chk({tag, ".data"}, 64'(O_DestValue), 64'(exp_d));
      chk({tag, ".regwe"}, 64'(O_RegWEn), 64'(exp_we));
      chk({tag, ".ccwe"}, 64'(O_CCWEn), 64'(exp_we));
      chk({tag, ".cc"}, 64'(O_CCValue), 64'(cc));
      chk({tag, ".pc"}, 64'(O_PC), 64'(pc));
      chk({tag, ".lock"}, 64'(O_LOCK), 64'(1));
      chk({tag, ".req"}, 64'(dmem.O_DMemReq), 64'(0));
      chk({tag, ".stall"}, 64'(O_MEMStallSignal), 64'(0));
      chk({tag, ".fault"}, 64'(O_MemFault), 64'(exp_fault));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] mar, mdr;
    logic [7:0]  op;
    int r, lat;
    bit vld;

    I_RESET = 1'b1;
    drive(OP_ADD, 1'b0, '0, '0, '0, '0, '0);
    I_LOCK = 1'b0;
    dmem.I_DMemRData = '0;
    #12;
    chk("rst.vld", 64'(O_MEM_Valid), 64'(0));
    chk("rst.lock", 64'(O_LOCK), 64'(0));
    chk("rst.req", 64'(dmem.O_DMemReq), 64'(0));
    chk("rst.stall", 64'(O_MEMStallSignal), 64'(0));
    chk("rst.fault", 64'(O_MemFault), 64'(0));
    chk("rst.data", 64'(O_DestValue), 64'(0));
    chk("rst.addr", 64'(dmem.O_DMemAddr), 64'(0));
    I_RESET = 1'b0;

    mem[30'h40] = 32'hFFFF_FFFE;
    mem[30'h41] = 32'h0000_0000;
    exec("add", OP_ADD, 1'b1, 32'h0, 32'h0, 32'd5, 0);
    exec("stw20", OP_STW, 1'b1, 32'h20, 32'h1234, $urandom, 0);
    exec("ldw100", OP_LDW, 1'b1, 32'h100, 32'h0, $urandom, 2);
    exec("ldw20", OP_LDW, 1'b1, 32'h20, 32'h0, $urandom, 1);
    exec("ldw104", OP_LDW, 1'b1, 32'h104, 32'h0, $urandom, 0);
    exec("ldw_inv", OP_LDW, 1'b0, 32'h100, 32'h0, $urandom, 0);
    exec("ldb", OP_LDB, 1'b1, 32'h101, 32'h0, $urandom, 0);
    exec("stb", OP_STB, 1'b1, 32'h102, 32'h55, $urandom, 0);
    exec("ldw_lastack", OP_LDW, 1'b1, 32'h100, 32'h0, $urandom, TO - 1);

    drive(OP_ADD, 1'b1, 32'h77, '0, '0, 32'h9, 3'b001);
    I_LOCK = 1'b0;
    tick();
    chk("nolock.lock", 64'(O_LOCK), 64'(0));
    chk("nolock.vld", 64'(O_MEM_Valid), 64'(0));
    chk("nolock.regwe", 64'(O_RegWEn), 64'(0));

    drive(OP_ADD, 1'b1, 32'h88, '0, '0, 32'hA, 3'b010);
    dmem.I_DMemAck = 1'b1;
    tick();
    dmem.I_DMemAck = 1'b0;
    chk("idleack.req", 64'(dmem.O_DMemReq), 64'(0));
    chk("idleack.vld", 64'(O_MEM_Valid), 64'(1));
    chk("idleack.data", 64'(O_DestValue), 64'(32'hA));

    exec("ldw_timeout", OP_LDW, 1'b1, 32'h108, 32'h0, $urandom, TO + 4);

    drive(OP_LDW, 1'b1, 32'h99, 32'h300, '0, '0, 3'b001);
    tick();
    chk("midrst.req_before", 64'(dmem.O_DMemReq), 64'(1));
    #2;
    I_RESET = 1'b1;
    #1;
    chk("midrst.req", 64'(dmem.O_DMemReq), 64'(0));
    chk("midrst.stall", 64'(O_MEMStallSignal), 64'(0));
    chk("midrst.fault", 64'(O_MemFault), 64'(0));
    chk("midrst.pc", 64'(O_PC), 64'(0));
    chk("midrst.lock", 64'(O_LOCK), 64'(0));
    I_EX_Valid = 1'b0;
    I_RESET = 1'b0;
    exp_fault = 1'b0;
    tick();
    chk("midrst.idle", 64'(O_MEMStallSignal), 64'(0));

    exec("ldw_misal", OP_LDW, 1'b1, 32'h102, 32'h0, $urandom, 0);

`ifdef MEM_STAGE_MMIO_LEDR_EN
    drive(OP_STW, 1'b1, 32'h11, 32'hFFFF_F000, 32'h3FF, '0, 3'b010);
    tick();
    chk("mmio_st.ledr", 64'(O_LEDR), 64'(10'h3FF));
    chk("mmio_st.req", 64'(dmem.O_DMemReq), 64'(0));
    chk("mmio_st.vld", 64'(O_MEM_Valid), 64'(1));
    drive(OP_LDW, 1'b1, 32'h12, 32'hFFFF_F000, '0, '0, 3'b100);
    tick();
    chk("mmio_ld.data", 64'(O_DestValue), 64'(32'h3FF));
    chk("mmio_ld.cc", 64'(O_CCValue), 64'(3'b001));
    chk("mmio_ld.regwe", 64'(O_RegWEn), 64'(1));
    chk("mmio_ld.req", 64'(dmem.O_DMemReq), 64'(0));
`endif

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      vld = 1'b1;
      mar = 32'h200 + (32'($urandom_range(0, 7)) << 2);
      mdr = $urandom;
      lat = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
      case (r)
        0, 1:    op = OP_ADD;
        2: begin op = OP_ADD; vld = 1'($urandom_range(0, 1)); end
        3, 4:    op = OP_LDW;
        5, 6:    op = OP_STW;
        7:       op = OP_LDB;
        8:       op = OP_STB;
        default: begin
          op = r[0] ? OP_LDW : OP_STW;
          op = ($urandom_range(0, 1) == 1) ? OP_LDW : OP_STW;
          mar = mar + 32'($urandom_range(1, 3));
        end
      endcase
      exec("rand", op, vld, mar, mdr, $urandom, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
